sdram_fifo_bridge: RTL and testbench
====================================

// Module: sdram_fifo_bridge
// PURPOSE
// - Responder end of the CPU external-FIFO memory path: drains the CPU write-request FIFO and read-address FIFO, issues
//   Avalon-MM transfers to the SDRAM controller, and pushes returned read data into the read-data FIFO the CPU pops.
// - Sits between the three dual-clock FIFOs on the core side and the SDRAM controller; all logic runs in the SDRAM clock domain.
// PARAMETERS
// - MAX_OUTSTANDING  4   maximum accepted-but-unreturned reads (1..15)
// - RDQ_DEPTH        16  read-data FIFO depth in words; power of two
// - RDQ_UW           5   width of rdq_usedw, equal to log2(RDQ_DEPTH)+1
// PORTS
// - clk            in   1   clock
// - rst_n          in   1   asynchronous active-low reset
// - wq_empty       in   1   write-request FIFO empty; the FIFO is show-ahead
// - wq_data        in   41  {addr[24:0], data[15:0]} at the head of the write-request FIFO
// - wq_rdreq       out  1   pop write-request FIFO
// - raq_empty      in   1   read-address FIFO empty; the FIFO is show-ahead
// - raq_addr       in   25  read address at the head of the read-address FIFO
// - raq_rdreq      out  1   pop read-address FIFO
// - rdq_usedw      in   RDQ_UW  read-data FIFO occupancy, write side
// - rdq_wrreq      out  1   push read-data FIFO
// - rdq_data       out  16  read data word
// - avm_address    out  25  SDRAM word address
// - avm_writedata  out  16  write data
// - avm_write      out  1   write request
// - avm_read       out  1   read request
// - avm_waitrequest in  1   controller stall
// - avm_readdata   in   16  returned data
// - avm_readdatavalid in 1  returned data valid
// - busy           out  1   FSM not in IDLE, or reads outstanding
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; outstanding=0; every output 0, including the address and data registers.
// - FSM states: IDLE, WR, RD.
//   - IDLE, wq_empty=0: latch wq_data into the address/data regs, pulse wq_rdreq for 1 cycle, go to WR.
//     avm_write rises the next cycle.
//   - IDLE, wq_empty=1, raq_empty=0 and credit ok: latch raq_addr, pulse raq_rdreq, go to RD. avm_read rises the next cycle.
//   - credit ok := (outstanding < MAX_OUTSTANDING) && (rdq_usedw + outstanding < RDQ_DEPTH). Compute the sum at RDQ_UW+1 bits.
//   - Writes take strict priority over reads. This preserves read-after-write order for the same address.
//   - WR/RD: hold the address, data and strobe stable while avm_waitrequest=1. In the first cycle with waitrequest=0 the
//     transfer is accepted; drop the strobe next cycle and return to IDLE.
//   - Minimum spacing is 3 cycles per transfer: pop, strobe, idle.
// - Read return: rdq_wrreq and rdq_data are the registered avm_readdatavalid/avm_readdata, 1 cycle of latency.
//   - A beat with avm_readdatavalid=1 while outstanding=0 is an orphan. It is dropped and produces no rdq_wrreq.
// - outstanding counter:
//   - +1 on read acceptance (avm_read && !avm_waitrequest).
//   - -1 on rdq_wrreq, not on avm_readdatavalid, so a registered beat still holds a credit.
//   - Simultaneous increment and decrement leave the count unchanged. The counter never wraps; the credit check prevents it.
// - rdq_usedw is trusted as-is. The read-data FIFO can never overflow when the credit rule holds.
// - Reset mid-transfer: strobes drop immediately and the popped request is lost. Beats in flight after reset are orphans.
// - busy = (state != IDLE) || (outstanding != 0).
// CONFIGURATION
// - BRIDGE_STATS_EN defined: adds ports stat_wr_cnt, stat_rd_cnt and stat_orphan_cnt (all out, 32 bits).
//   - They count accepted writes, accepted reads and dropped orphan beats.
//   - They wrap at 2^32 and clear on reset.
// - BRIDGE_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.
// STRUCTURE
// - Shared header bridge_defs.vh holds the state encodings (ST_IDLE=2'd0, ST_WR=2'd1, ST_RD=2'd2),
//   SDRAM_AW=25 and SDRAM_DW=16.
// - One sub-module, bridge_credit_ctr: the outstanding counter plus the credit-ok compare.
//   The FSM, datapath registers and stats live in the top level.
// TESTING
// - Single write: wq_data={25'h000123,16'hBEEF} with waitrequest=0 -> wq_rdreq for 1 cycle, then 1 cycle of
//   avm_write with addr 0x123 and data 0xBEEF.
// - Read with 5 stall cycles: raq_addr=0x10 and avm_waitrequest=1 for 5 cycles -> avm_read is held 6 cycles with
//   constant address; readdatavalid with 0x5A5A -> rdq_wrreq 1 cycle later with 0x5A5A.
// - Credit limit: MAX_OUTSTANDING=4, 8 queued reads, controller withholding data -> exactly 4 avm_read acceptances.
//   Each returned beat frees 1 issue.
// - FIFO back-pressure: rdq_usedw=14, RDQ_DEPTH=16 -> at most 2 reads outstanding; no overflow.
// - Priority and orphans: write and read queued together -> write issued first; readdatavalid with outstanding=0 ->
//   no rdq_wrreq, stat_orphan_cnt=1 when BRIDGE_STATS_EN is defined.
// - Reset mid-WR with waitrequest=1 -> avm_write and busy go to 0 asynchronously. After release, a queued read proceeds normally.

Source files
------------

// File: rtl/sdram_fifo_bridge_pkg.sv
// Shared definitions for the SDRAM FIFO bridge: FSM state encodings,
// SDRAM address/data widths and write-request field helpers.
package sdram_fifo_bridge_pkg;

    localparam int SDRAM_AW = 25;
    localparam int SDRAM_DW = 16;
    localparam int WQ_W     = SDRAM_AW + SDRAM_DW;
    // Outstanding-read counter width; MAX_OUTSTANDING is limited to 15
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    // Address field of a write-request word {addr, data}
    function automatic logic [SDRAM_AW-1:0] wq_addr(input logic [WQ_W-1:0] w);
        return w[WQ_W-1:SDRAM_DW];
    endfunction

    // Data field of a write-request word {addr, data}
    function automatic logic [SDRAM_DW-1:0] wq_wdata(input logic [WQ_W-1:0] w);
        return w[SDRAM_DW-1:0];
    endfunction

endpackage

// File: rtl/sdram_fifo_bridge_credit_ctr.sv
// Outstanding-read counter and read credit check for the SDRAM FIFO bridge.
// A credit is available when fewer than MAX_OUTSTANDING reads are in flight
// and the read-data FIFO has room for every in-flight beat plus one more.
module bridge_credit_ctr
    import sdram_fifo_bridge_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RDQ_DEPTH       = 16,
    parameter int RDQ_UW          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic [RDQ_UW-1:0] i_rdq_usedw,
    output logic [CNT_W-1:0]  o_outstanding,
    output logic              o_credit_ok
);

    // One extra bit so usedw + outstanding cannot overflow the compare
    localparam int SW = RDQ_UW + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec;
    logic [SW-1:0]    w_sum;

    // A decrement is only honoured with a non-zero count, so a stray beat can never wrap it
    assign w_dec = i_dec && (r_cnt != '0);
    assign w_sum = {1'b0, i_rdq_usedw} + SW'(r_cnt);

    assign o_outstanding = r_cnt;
    assign o_credit_ok   = (r_cnt < CNT_W'(MAX_OUTSTANDING)) && (w_sum < SW'(RDQ_DEPTH));

    // Count reads accepted by the controller but not yet pushed into the read-data FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec && !i_inc) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sdram_fifo_bridge.sv
// SDRAM FIFO bridge: drains the CPU write-request and read-address FIFOs,
// issues Avalon-MM transfers to the SDRAM controller and pushes returned
// read data into the read-data FIFO. Writes have strict priority over reads.
// Optional build macro BRIDGE_STATS_EN adds 32-bit wrapping counters of
// accepted writes, accepted reads and dropped orphan read beats.
module sdram_fifo_bridge
    import sdram_fifo_bridge_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RDQ_DEPTH       = 16,
    parameter int RDQ_UW          = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wq_empty,
    input  logic [WQ_W-1:0]     wq_data,
    output logic                wq_rdreq,
    input  logic                raq_empty,
    input  logic [SDRAM_AW-1:0] raq_addr,
    output logic                raq_rdreq,
    input  logic [RDQ_UW-1:0]   rdq_usedw,
    output logic                rdq_wrreq,
    output logic [SDRAM_DW-1:0] rdq_data,
    output logic [SDRAM_AW-1:0] avm_address,
    output logic [SDRAM_DW-1:0] avm_writedata,
    output logic                avm_write,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    input  logic [SDRAM_DW-1:0] avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                busy
`ifdef BRIDGE_STATS_EN
    ,
    output logic [31:0]         stat_wr_cnt,
    output logic [31:0]         stat_rd_cnt,
    output logic [31:0]         stat_orphan_cnt
`endif
);

    state_t              r_state;
    logic [SDRAM_AW-1:0] r_addr;
    logic [SDRAM_DW-1:0] r_wdata;
    logic                r_wq_rdreq;
    logic                r_raq_rdreq;
    logic                r_avm_write;
    logic                r_avm_read;
    logic                r_rdq_wrreq;
    logic [SDRAM_DW-1:0] r_rdq_data;

    logic [CNT_W-1:0]    w_outstanding;
    logic                w_credit_ok;
    logic                w_rd_accept;

    assign w_rd_accept = r_avm_read && !avm_waitrequest;

    bridge_credit_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .RDQ_DEPTH       (RDQ_DEPTH),
        .RDQ_UW          (RDQ_UW)
    ) u_credit (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inc         (w_rd_accept),
        .i_dec         (r_rdq_wrreq),
        .i_rdq_usedw   (rdq_usedw),
        .o_outstanding (w_outstanding),
        .o_credit_ok   (w_credit_ok)
    );

    // Transfer FSM: pop a request, raise the strobe a cycle later, hold it through waitrequest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wq_rdreq  <= 1'b0;
            r_raq_rdreq <= 1'b0;
            r_avm_write <= 1'b0;
            r_avm_read  <= 1'b0;
        end else begin
            r_wq_rdreq  <= 1'b0;
            r_raq_rdreq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!wq_empty) begin
                        r_addr     <= wq_addr(wq_data);
                        r_wdata    <= wq_wdata(wq_data);
                        r_wq_rdreq <= 1'b1;
                        r_state    <= ST_WR;
                    end else if (!raq_empty && w_credit_ok) begin
                        r_addr      <= raq_addr;
                        r_raq_rdreq <= 1'b1;
                        r_state     <= ST_RD;
                    end
                end
                ST_WR: begin
                    if (!r_avm_write) begin
                        r_avm_write <= 1'b1;
                    end else if (!avm_waitrequest) begin
                        r_avm_write <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (!r_avm_read) begin
                        r_avm_read <= 1'b1;
                    end else if (!avm_waitrequest) begin
                        r_avm_read <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register returned beats; a beat arriving with nothing outstanding is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdq_wrreq <= 1'b0;
            r_rdq_data  <= '0;
        end else begin
            r_rdq_wrreq <= avm_readdatavalid && (w_outstanding != '0);
            if (avm_readdatavalid) begin
                r_rdq_data <= avm_readdata;
            end
        end
    end

`ifdef BRIDGE_STATS_EN
    logic w_wr_accept;
    logic w_orphan;

    assign w_wr_accept = r_avm_write && !avm_waitrequest;
    assign w_orphan    = avm_readdatavalid && (w_outstanding == '0);

    // Free-running statistics, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_cnt     <= '0;
            stat_rd_cnt     <= '0;
            stat_orphan_cnt <= '0;
        end else begin
            if (w_wr_accept) stat_wr_cnt     <= stat_wr_cnt + 32'd1;
            if (w_rd_accept) stat_rd_cnt     <= stat_rd_cnt + 32'd1;
            if (w_orphan)    stat_orphan_cnt <= stat_orphan_cnt + 32'd1;
        end
    end
`endif

    assign wq_rdreq      = r_wq_rdreq;
    assign raq_rdreq     = r_raq_rdreq;
    assign avm_address   = r_addr;
    assign avm_writedata = r_wdata;
    assign avm_write     = r_avm_write;
    assign avm_read      = r_avm_read;
    assign rdq_wrreq     = r_rdq_wrreq;
    assign rdq_data      = r_rdq_data;
    assign busy          = (r_state != ST_IDLE) || (w_outstanding != '0);

endmodule

// File: tb/tb_sdram_fifo_bridge.sv
// Bench for sdram_fifo_bridge: show-ahead FIFO models, an Avalon slave with
// configurable stalls and return latency, a read-data FIFO occupancy model and
// a scoreboard monitor. Build with BRIDGE_STATS_EN to also check statistics.
module tb_sdram_fifo_bridge;

    localparam int MAXO  = 4;
    localparam int DEPTH = 16;
    localparam int UW    = 5;

    logic        clk;
    logic        rst_n;
    logic        wq_empty;
    logic [40:0] wq_data;
    logic        wq_rdreq;
    logic        raq_empty;
    logic [24:0] raq_addr;
    logic        raq_rdreq;
    logic [UW-1:0] rdq_usedw;
    logic        rdq_wrreq;
    logic [15:0] rdq_data;
    logic [24:0] avm_address;
    logic [15:0] avm_writedata;
    logic        avm_write;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [15:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
`ifdef BRIDGE_STATS_EN
    logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_orphan_cnt;
`endif

    sdram_fifo_bridge #(.MAX_OUTSTANDING(MAXO), .RDQ_DEPTH(DEPTH), .RDQ_UW(UW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wq_empty(wq_empty), .wq_data(wq_data), .wq_rdreq(wq_rdreq),
        .raq_empty(raq_empty), .raq_addr(raq_addr), .raq_rdreq(raq_rdreq),
        .rdq_usedw(rdq_usedw), .rdq_wrreq(rdq_wrreq), .rdq_data(rdq_data),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_write(avm_write), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .busy(busy)
`ifdef BRIDGE_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_orphan_cnt(stat_orphan_cnt)
`endif
    );

    typedef struct { logic [15:0] d; int due; } beat_t;

    // Reference state
    logic [40:0] wq_q[$];
    logic [24:0] raq_q[$];
    logic [40:0] exp_wr[$];
    logic [24:0] exp_rd[$];
    beat_t       ret_q[$];
    beat_t       exp_rdq[$];
    int inflight = 0, fill = 0, cyc = 0;
    int wr_acc = 0, rd_acc = 0, orphans = 0, rdq_seen = 0;
    // Environment controls
    int wait_mode = 2, stall_left = 0, hold_ret = 0, rel_budget = 0;
    int drain_en = 1, orphan_req = 0, fix_en = 0;
    logic [15:0] fix_val = 16'h0;
    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); cyc++; end
    initial begin
        #400000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    // Environment: FIFO heads, Avalon slave, read-data FIFO occupancy
    initial begin
        logic w, v;
        logic [15:0] d;
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && wq_rdreq) begin
                chk("wq_pop_nonempty", wq_q.size() > 0, 1);
                if (wq_q.size() > 0) void'(wq_q.pop_front());
            end
            if (rst_n && raq_rdreq) begin
                chk("raq_pop_nonempty", raq_q.size() > 0, 1);
                if (raq_q.size() > 0) void'(raq_q.pop_front());
            end
            w = 1'b0;
            case (wait_mode)
                0: w = ($urandom_range(0, 9) < 4);
                1: w = 1'b1;
                3: if ((avm_write || avm_read) && stall_left > 0) begin w = 1'b1; stall_left--; end
                default: w = 1'b0;
            endcase
            avm_waitrequest = w;
            if (rst_n && avm_write && !w) wr_acc++;
            if (rst_n && avm_read && !w) begin
                rd_acc++;
                inflight++;
                b.d = fix_en ? fix_val : 16'($urandom);
                b.due = cyc + $urandom_range(1, 4);
                ret_q.push_back(b);
            end
            if (rst_n && rdq_wrreq) begin fill++; inflight--; rdq_seen++; end
            if (drain_en != 0 && fill > 0 && $urandom_range(0, 1) == 1) fill--;
            v = 1'b0;
            d = 16'($urandom);
            if (ret_q.size() > 0 && ret_q[0].due <= cyc && (hold_ret == 0 || rel_budget > 0)) begin
                if (hold_ret != 0) rel_budget--;
                b = ret_q.pop_front();
                v = 1'b1;
                d = b.d;
                b.due = cyc + 1;
                exp_rdq.push_back(b);
            end else if (orphan_req != 0) begin
                orphan_req = 0;
                orphans++;
                v = 1'b1;
            end
            avm_readdatavalid = v;
            avm_readdata = d;
            wq_empty = (wq_q.size() == 0);
            wq_data = (wq_q.size() > 0) ? wq_q[0] : 41'h0;
            raq_empty = (raq_q.size() == 0);
            raq_addr = (raq_q.size() > 0) ? raq_q[0] : 25'h0;
            rdq_usedw = UW'(fill);
        end
    end

    // Monitor: scoreboard pops on every accepted transfer and every read-data push
    initial begin
        logic        prev_stall = 1'b0;
        logic [1:0]  prev_strb = 2'b00;
        logic [24:0] prev_addr = '0;
        logic [15:0] prev_data = '0;
        logic [40:0] ew;
        logic [24:0] ea;
        beat_t       eb;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_strobe", {avm_write, avm_read}, prev_strb);
                    chk("hold_addr", avm_address, prev_addr);
                    if (prev_strb == 2'b10) chk("hold_wdata", avm_writedata, prev_data);
                end
                if (avm_write && avm_read) chk("both_strobes", 1, 0);
                if (avm_write && !avm_waitrequest) begin
                    if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        ew = exp_wr.pop_front();
                        chk("wr_addr", avm_address, ew[40:16]);
                        chk("wr_data", avm_writedata, ew[15:0]);
                    end
                end
                if (avm_read && !avm_waitrequest) begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                    else begin
                        ea = exp_rd.pop_front();
                        chk("rd_addr", avm_address, ea);
                    end
                    chk("credit_max", inflight <= MAXO, 1);
                    chk("credit_fifo", fill + inflight <= DEPTH, 1);
                end
                if (exp_rdq.size() > 0 && exp_rdq[0].due == cyc) begin
                    eb = exp_rdq.pop_front();
                    chk("rdq_wrreq", rdq_wrreq, 1);
                    chk("rdq_data", rdq_data, eb.d);
                    chk("rdq_no_overflow", fill <= DEPTH, 1);
                end else if (rdq_wrreq) begin
                    chk("rdq_unexpected", 1, 0);
                end
                prev_stall = (avm_write || avm_read) && avm_waitrequest;
                prev_strb = {avm_write, avm_read};
                prev_addr = avm_address;
                prev_data = avm_writedata;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic push_wr(input logic [24:0] a, input logic [15:0] d);
        wq_q.push_back({a, d});
        exp_wr.push_back({a, d});
    endtask

    task automatic push_rd(input logic [24:0] a);
        raq_q.push_back(a);
        exp_rd.push_back(a);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (wq_q.size() == 0 && raq_q.size() == 0 && ret_q.size() == 0 && exp_rdq.size() == 0
                && inflight == 0 && !busy) break;
            tick(1);
        end
        chk(name, k < budget, 1);
    endtask

    initial begin
        int base;
        int cnt;
        logic [24:0] ra;
        logic [15:0] rd;
        rst_n = 1'b0;
        wq_empty = 1'b1; wq_data = '0; raq_empty = 1'b1; raq_addr = '0;
        rdq_usedw = '0; avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        tick(3);
        chk("rst_outputs", {wq_rdreq, raq_rdreq, rdq_wrreq, avm_write, avm_read, busy}, 6'b0);
        chk("rst_addr", avm_address, 25'h0);
        chk("rst_wdata", avm_writedata, 16'h0);
        chk("rst_rdata", rdq_data, 16'h0);
        rst_n = 1'b1;
        tick(2);

        // Single write
        wait_mode = 2;
        push_wr(25'h000123, 16'hBEEF);
        for (int k = 0; k < 20 && !wq_rdreq; k++) tick(1);
        chk("t1_pop", wq_rdreq, 1);
        tick(1);
        chk("t1_pop_1cyc_strobe", {wq_rdreq, avm_write}, 2'b01);
        chk("t1_addr", avm_address, 25'h123);
        chk("t1_data", avm_writedata, 16'hBEEF);
        tick(1);
        chk("t1_strobe_1cyc", avm_write, 0);
        wait_idle("t1_idle", 50);

        // Read with 5 stall cycles
        wait_mode = 3; stall_left = 5; fix_en = 1; fix_val = 16'h5A5A;
        push_rd(25'h10);
        for (int k = 0; k < 20 && !avm_read; k++) tick(1);
        cnt = 0;
        for (int k = 0; k < 20 && avm_read; k++) begin
            chk("t2_addr_const", avm_address, 25'h10);
            cnt++;
            tick(1);
        end
        chk("t2_read_cycles", cnt, 6);
        for (int k = 0; k < 20 && !rdq_wrreq; k++) tick(1);
        chk("t2_rdq_data", {rdq_wrreq, rdq_data}, {1'b1, 16'h5A5A});
        fix_en = 0;
        wait_idle("t2_idle", 50);

        // Credit limit with the controller withholding data
        wait_mode = 2; hold_ret = 1; rel_budget = 0;
        base = rd_acc;
        for (int i = 0; i < 8; i++) push_rd(25'h100 + 25'(i));
        tick(60);
        chk("t3_max_outstanding", rd_acc - base, 4);
        rel_budget = 1;
        tick(30);
        chk("t3_one_freed", rd_acc - base, 5);
        hold_ret = 0;
        wait_idle("t3_idle", 300);
        chk("t3_all_reads", rd_acc - base, 8);

        // Read-data FIFO back-pressure
        drain_en = 0; fill = 14;
        base = rd_acc;
        for (int i = 0; i < 4; i++) push_rd(25'h200 + 25'(i));
        tick(80);
        chk("t4_backpressure", rd_acc - base, 2);
        chk("t4_fifo_full", fill, DEPTH);
        drain_en = 1;
        wait_idle("t4_idle", 400);

        // Write priority and orphan beat
        push_wr(25'h0ABCDE, 16'h1357);
        push_rd(25'h0ABCDE);
        for (int k = 0; k < 20 && !(avm_write || avm_read); k++) tick(1);
        chk("t5_write_first", {avm_write, avm_read}, 2'b10);
        wait_idle("t5_idle", 100);
        base = rdq_seen;
        orphan_req = 1;
        tick(6);
        chk("t5_orphan_dropped", rdq_seen - base, 0);
        chk("t5_orphan_not_busy", busy, 0);
`ifdef BRIDGE_STATS_EN
        chk("t5_stat_orphan", stat_orphan_cnt, 32'd1);
`endif

        // Reset in the middle of a stalled write
        wait_mode = 1;
        push_wr(25'h1AB, 16'h1234);
        for (int k = 0; k < 20 && !avm_write; k++) tick(1);
        chk("t6_write_up", avm_write, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_write_low", avm_write, 0);
        chk("t6_async_busy_low", busy, 0);
        void'(exp_wr.pop_front());
        tick(2);
        wr_acc = 0; rd_acc = 0; orphans = 0;
        wait_mode = 2;
        rst_n = 1'b1;
        tick(1);
        push_rd(25'h77);
        wait_idle("t6_idle", 100);
        chk("t6_read_after_reset", rd_acc, 1);

        // Randomized traffic
        wait_mode = 0; drain_en = 1;
        for (int i = 0; i < 500; i++) begin
            ra = 25'($urandom_range(0, 63));
            rd = 16'($urandom);
            if (wq_q.size() < 6 && $urandom_range(0, 3) == 0) push_wr(ra, rd);
            ra = 25'($urandom_range(0, 63));
            if (raq_q.size() < 6 && $urandom_range(0, 2) == 0) push_rd(ra);
            tick(1);
        end
        wait_idle("rand_idle", 3000);
        orphan_req = 1;
        tick(6);
        chk("end_exp_wr_empty", exp_wr.size(), 0);
        chk("end_exp_rd_empty", exp_rd.size(), 0);
        chk("end_exp_rdq_empty", exp_rdq.size(), 0);
`ifdef BRIDGE_STATS_EN
        chk("stat_wr", stat_wr_cnt, 32'(wr_acc));
        chk("stat_rd", stat_rd_cnt, 32'(rd_acc));
        chk("stat_orphan", stat_orphan_cnt, 32'(orphans));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
